// File: rtl/crypto_round_sequencer_if.sv
// Handshake and round-unit bus for crypto_round_sequencer.
// slave  : the sequencer side (accepts requests, drives the round unit, returns results).
// master : the requester / round-unit / consumer side.
interface crypto_round_sequencer_if;
  logic        in_valid;
  logic        in_ready;
  logic        in_mode;
  logic [15:0] in_key;
  logic [15:0] in_data;
  logic        rnd_mode;
  logic [15:0] rnd_state;
  logic [15:0] rnd_key;
  logic [15:0] rnd_result;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;

  modport slave (
    input  in_valid, in_mode, in_key, in_data, rnd_result, out_ready,
    output in_ready, rnd_mode, rnd_state, rnd_key, out_valid, out_data
  );

  modport master (
    output in_valid, in_mode, in_key, in_data, rnd_result, out_ready,
    input  in_ready, rnd_mode, rnd_state, rnd_key, out_valid, out_data
  );
endinterface

// File: rtl/crypto_round_sequencer.sv
// Iterative round controller for the 16-bit cipher datapath.
// Expands a round-key schedule from the request key, then drives an external
// combinational round unit once per cycle, feeding its result back as state.
// Optional feature macro: SEQ_KEY_CACHE_EN -- reuse the stored schedule when
// a new request carries the same key as the one last expanded.
module crypto_round_sequencer #(
  parameter int NUM_ROUNDS = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  crypto_round_sequencer_if.slave  bus
);

  localparam int          DATA_W = 16;
  localparam logic [3:0]  LAST   = 4'(NUM_ROUNDS);

  typedef enum logic [1:0] {IDLE, KEYEXP, ROUND, DONE} state_t;

  state_t              state_q;
  logic [3:0]          ctr_q;
  logic                mode_q;
  logic [DATA_W-1:0]   blk_q;
  // Sized to the full 4-bit counter range so the counter indexes it directly.
  logic [DATA_W-1:0]   kreg_q [16];
  logic                in_ready_q;
  logic                out_valid_q;
  logic [DATA_W-1:0]   out_data_q;

  logic                in_round;
  logic [3:0]          rk_idx;
  logic                accept;

`ifdef SEQ_KEY_CACHE_EN
  logic                cache_vld_q;
  logic                cache_hit;
  assign cache_hit = cache_vld_q && (bus.in_key == kreg_q[0]);
`endif

  function automatic logic [DATA_W-1:0] rotl3(input logic [DATA_W-1:0] k);
    return {k[12:0], k[15:13]};
  endfunction

  function automatic logic [DATA_W-1:0] key_step(input logic [DATA_W-1:0] k,
                                                 input logic [3:0]        r);
    return rotl3(k) ^ {12'h000, r};
  endfunction

  assign accept   = bus.in_valid && in_ready_q;
  assign in_round = (state_q == ROUND);
  // Decrypt walks the schedule backwards; modular 4-bit arithmetic is exact
  // because the result always lies in 1..NUM_ROUNDS.
  assign rk_idx   = mode_q ? (LAST + 4'd1 - ctr_q) : ctr_q;

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.rnd_mode  = in_round & mode_q;
  assign bus.rnd_state = in_round ? blk_q : '0;
  assign bus.rnd_key   = in_round ? kreg_q[rk_idx] : '0;

  // Sequencer FSM: accept, expand keys, iterate rounds, hold result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ctr_q       <= 4'd0;
      mode_q      <= 1'b0;
      blk_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      for (int i = 0; i < 16; i++) kreg_q[i] <= '0;
`ifdef SEQ_KEY_CACHE_EN
      cache_vld_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          in_ready_q <= 1'b1;
          if (accept) begin
            in_ready_q <= 1'b0;
            mode_q     <= bus.in_mode;
            kreg_q[0]  <= bus.in_key;
            blk_q      <= bus.in_mode ? bus.in_data : (bus.in_data ^ bus.in_key);
            ctr_q      <= 4'd1;
`ifdef SEQ_KEY_CACHE_EN
            if (cache_hit) begin
              state_q <= ROUND;
            end else begin
              cache_vld_q <= 1'b0;
              state_q     <= KEYEXP;
            end
`else
            state_q    <= KEYEXP;
`endif
          end
        end
        KEYEXP: begin
          kreg_q[ctr_q] <= key_step(kreg_q[ctr_q - 4'd1], ctr_q);
          if (ctr_q == LAST) begin
            ctr_q   <= 4'd1;
            state_q <= ROUND;
`ifdef SEQ_KEY_CACHE_EN
            cache_vld_q <= 1'b1;
`endif
          end else begin
            ctr_q <= ctr_q + 4'd1;
          end
        end
        ROUND: begin
          blk_q <= bus.rnd_result;
          if (ctr_q == LAST) begin
            out_data_q  <= mode_q ? (bus.rnd_result ^ kreg_q[0]) : bus.rnd_result;
            out_valid_q <= 1'b1;
            ctr_q       <= 4'd0;
            state_q     <= DONE;
          end else begin
            ctr_q <= ctr_q + 4'd1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_crypto_round_sequencer.sv
// Directed bench for crypto_round_sequencer with an XOR stub round unit
// (result = state ^ key) and a scoreboard of expected final blocks.
module tb_crypto_round_sequencer;

  localparam int NR = 4;
`ifdef SEQ_KEY_CACHE_EN
  localparam bit CACHE_EN = 1'b1;
`else
  localparam bit CACHE_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  crypto_round_sequencer_if bus();

  crypto_round_sequencer #(.NUM_ROUNDS(NR)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  assign bus.rnd_result = bus.rnd_state ^ bus.rnd_key;

  int          checks   = 0;
  int          failures = 0;
  logic [15:0] sb_q [$];
  bit          m_cache_vld = 1'b0;
  logic [15:0] m_cache_key = 16'h0000;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] rotl3_m(input logic [15:0] k);
    return {k[12:0], k[15:13]};
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"},  {15'b0, bus.in_ready},  16'h0000);
    check({tag, "_out_valid"}, {15'b0, bus.out_valid}, 16'h0000);
    check({tag, "_out_data"},  bus.out_data,           16'h0000);
    check({tag, "_rnd_state"}, bus.rnd_state,          16'h0000);
    check({tag, "_rnd_key"},   bus.rnd_key,            16'h0000);
    check({tag, "_rnd_mode"},  {15'b0, bus.rnd_mode},  16'h0000);
  endtask

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.in_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    if (!ok) check("in_ready_timeout", {15'b0, bus.in_ready}, 16'h0001);
  endtask

  // Full request: model the schedule and rounds, check every cycle, then
  // optionally hold out_ready low for 'hold' cycles before the handshake.
  task automatic run_req(input logic mode, input logic [15:0] key,
                         input logic [15:0] data, input int hold);
    logic [15:0] ks [16];
    logic [15:0] st, rk, exp_out, got_exp;
    bit          hit, ok;
    int          lat, base, j;
    ks[0] = key;
    for (int r = 1; r <= NR; r++) ks[r] = rotl3_m(ks[r-1]) ^ 16'(r);
    st = mode ? data : (data ^ key);
    for (int r = 1; r <= NR; r++) st = st ^ (mode ? ks[NR+1-r] : ks[r]);
    exp_out = mode ? (st ^ key) : st;
    sb_q.push_back(exp_out);
    hit  = CACHE_EN && m_cache_vld && (key == m_cache_key);
    lat  = hit ? NR : 2 * NR;
    base = lat - NR;

    wait_ready(ok);
    if (!ok) return;
    bus.out_ready = (hold == 0);
    bus.in_valid  = 1'b1;
    bus.in_mode   = mode;
    bus.in_key    = key;
    bus.in_data   = data;
    @(posedge clk); #1;
    bus.in_valid  = 1'b0;
    bus.in_data   = 16'hDEAD;

    st = mode ? data : (data ^ key);
    for (int n = 0; n < lat; n++) begin
      check("out_valid_busy", {15'b0, bus.out_valid}, 16'h0000);
      if (n >= base) begin
        j  = n - base + 1;
        rk = mode ? ks[NR+1-j] : ks[j];
        check("rnd_key",   bus.rnd_key,            rk);
        check("rnd_state", bus.rnd_state,          st);
        check("rnd_mode",  {15'b0, bus.rnd_mode},  {15'b0, mode});
        st = st ^ rk;
      end else begin
        check("rnd_key_keyexp", bus.rnd_key, 16'h0000);
      end
      @(posedge clk); #1;
    end

    got_exp = sb_q.pop_front();
    check("out_valid_done", {15'b0, bus.out_valid}, 16'h0001);
    check("out_data",       bus.out_data,           got_exp);
    check("rnd_key_done",   bus.rnd_key,            16'h0000);

    for (int h = 1; h < hold; h++) begin
      bus.in_valid = 1'b1;
      bus.in_mode  = ~mode;
      bus.in_key   = 16'($urandom);
      bus.in_data  = 16'($urandom);
      @(posedge clk); #1;
      check("bp_out_valid", {15'b0, bus.out_valid}, 16'h0001);
      check("bp_out_data",  bus.out_data,           got_exp);
      check("bp_in_ready",  {15'b0, bus.in_ready},  16'h0000);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check("hs_out_valid", {15'b0, bus.out_valid}, 16'h0000);
    check("hs_in_ready",  {15'b0, bus.in_ready},  16'h0001);
    m_cache_vld = 1'b1;
    m_cache_key = key;
  endtask

  // Request aborted by reset sampled on edge 6 after accept.
  task automatic run_abort(input logic mode, input logic [15:0] key, input logic [15:0] data);
    bit ok;
    wait_ready(ok);
    if (!ok) return;
    bus.in_valid = 1'b1;
    bus.in_mode  = mode;
    bus.in_key   = key;
    bus.in_data  = data;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    check_reset_outputs("abort");
    rst_n = 1'b1;
    m_cache_vld = 1'b0;
  endtask

  // Directed sequence.
  initial begin
    bus.in_valid  = 1'b0;
    bus.in_mode   = 1'b0;
    bus.in_key    = 16'h0000;
    bus.in_data   = 16'h0000;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;

    run_req(1'b0, 16'h0001, 16'h1234, 0);
    run_req(1'b1, 16'h0001, 16'h02B9, 0);
    run_req(1'b0, 16'h0001, 16'h1234, 5);
    for (int i = 0; i < 4; i++)
      run_req(1'($urandom), 16'($urandom), 16'($urandom), int'($urandom_range(0, 2)));

    run_abort(1'b0, 16'h0001, 16'h1234);
    run_req(1'b0, 16'h0001, 16'h1234, 0);
    run_req(1'b0, 16'h0001, 16'h1234, 0);
    run_req(1'b0, 16'h0002, 16'h1234, 0);
    run_req(1'b1, 16'h0002, 16'h55AA, 0);

    check("sb_empty", 16'(sb_q.size()), 16'h0000);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
